rr_mux_4to1: RTL

- Four-channel round-robin collector: merges four valid/ready input streams onto one registered output stream.
- Emits, with each word, the 2-bit channel id `s` of its source, so a downstream `demux_4to1` can route words back out by `s`.
- It is the gather end of the existing 1:4 distribution path.
- Sits between channel producers and the shared link or demux.

---
 rtl/rr_mux_4to1.sv | 71 +++++++
 1 files changed

// File: rtl/rr_mux_4to1.sv
// rr_mux_4to1: four-channel round-robin collector onto one registered stream tagged with source id s.
// Optional per-channel saturating transfer counters are built when RR_MUX_CNT_EN is defined.
module rr_mux_4to1 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic          v0,
  input  logic          v1,
  input  logic          v2,
  input  logic          v3,
  output logic          rdy0,
  output logic          rdy1,
  output logic          rdy2,
  output logic          rdy3,
  output logic [DW-1:0] y,
  output logic [1:0]    s,
  output logic          y_valid,
  input  logic          y_ready,
  input  logic [1:0]    cnt_sel,
  output logic [15:0]   cnt
);
  logic [3:0] vv, rdy;
  logic [1:0] last, p1, p2, p3, g;
  logic load, any;
  logic [DW-1:0] dg;
  assign vv = {v3, v2, v1, v0};
  assign load = !y_valid || y_ready;
  assign any = |vv;
  assign p1 = last + 2'd1;
  assign p2 = last + 2'd2;
  assign p3 = last + 2'd3;
  assign g = vv[p1] ? p1 : vv[p2] ? p2 : vv[p3] ? p3 : last;
  assign dg = g == 2'd0 ? d0 : g == 2'd1 ? d1 : g == 2'd2 ? d2 : d3;
  // rdy is gated by rst so no producer sees a handshake while reset is asserted
  assign rdy = {4{load & any & !rst}} & (4'b0001 << g);
  assign {rdy3, rdy2, rdy1, rdy0} = rdy;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y <= '0;
      s <= 2'b00;
      y_valid <= 1'b0;
      last <= 2'd3;
    end else if (load) begin
      y_valid <= any;
      if (any) begin
        y <= dg;
        s <= g;
        last <= g;
      end
    end
`ifdef RR_MUX_CNT_EN
  logic [15:0] c [4];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 4; i++) c[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (rdy[i] && c[i] != 16'hFFFF) c[i] <= c[i] + 16'd1;
    end
  assign cnt = c[cnt_sel];
`else
  logic unused_sel;
  assign unused_sel = ^cnt_sel;
  assign cnt = 16'h0000;
`endif
endmodule
